// File: rtl/label_alloc_writer.sv
// Label table writer: sweeps the table to zero after reset/clear, then accepts label
// definitions and bump-allocates a contiguous data-memory region for each one.
module label_alloc_writer #(
   parameter int unsigned LBIDWidth = 8,
   parameter int unsigned MemDepth  = 65536
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [LBIDWidth-1:0] req_lbid,
   input  logic [5:0]           req_typ,
   input  logic [15:0]          req_count,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [15:0]          resp_base,
   output logic                 busy,
   output logic [LBIDWidth-1:0] lbidw,
   output logic [5:0]           typw,
   output logic [15:0]          basew,
   output logic [15:0]          countw,
   output logic                 we
);

   localparam int unsigned          NumLabels = 2 ** LBIDWidth;
   localparam logic [16:0]          MemLimit  = 17'(MemDepth);
   localparam logic [LBIDWidth-1:0] IdxMax    = '1;

   localparam logic [1:0] ErrNone     = 2'd0;
   localparam logic [1:0] ErrOverflow = 2'd1;
   localparam logic [1:0] ErrDefined  = 2'd2;

   typedef enum logic [1:0] {StInit, StIdle, StWrite} state_e;

   state_e                 state_q;
   logic [LBIDWidth-1:0]   idx_q;
   logic [16:0]            next_base_q;
   logic [NumLabels-1:0]   defined_q;

   logic [16:0]            alloc_end;
   logic                   hit_defined;
   logic                   overflow;
   logic                   accept;

   // Request checks evaluated in the accept cycle; 17 bits holds next_base + count without wrap.
   always_comb begin
      alloc_end   = next_base_q + {1'b0, req_count};
      hit_defined = defined_q[req_lbid];
      overflow    = (alloc_end > MemLimit) || (next_base_q == MemLimit);
      accept      = (state_q == StIdle) && req_ready && req_valid;
   end

   // Control FSM with registered outputs; clr overrides everything except reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StInit;
         idx_q       <= '0;
         next_base_q <= '0;
         defined_q   <= '0;
         we          <= 1'b0;
         lbidw       <= '0;
         typw        <= '0;
         basew       <= '0;
         countw      <= '0;
         req_ready   <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ErrNone;
         resp_base   <= '0;
         busy        <= 1'b1;
      end else if (clr) begin
         // A write already on the table port this cycle still lands; only future state resets.
         state_q     <= StInit;
         idx_q       <= '0;
         next_base_q <= '0;
         defined_q   <= '0;
         we          <= 1'b0;
         lbidw       <= '0;
         typw        <= '0;
         basew       <= '0;
         countw      <= '0;
         req_ready   <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ErrNone;
         busy        <= 1'b1;
      end else begin
         unique case (state_q)
            StInit: begin
               we        <= 1'b1;
               lbidw     <= idx_q;
               typw      <= '0;
               basew     <= '0;
               countw    <= '0;
               busy      <= 1'b1;
               req_ready <= 1'b0;
               idx_q     <= idx_q + 1'b1;
               if (idx_q == IdxMax) begin
                  state_q <= StIdle;
               end
            end
            StIdle: begin
               we       <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               err      <= 1'b0;
               err_code <= ErrNone;
               if (accept) begin
                  state_q   <= StWrite;
                  req_ready <= 1'b0;
                  done      <= 1'b1;
                  if (hit_defined) begin
                     err      <= 1'b1;
                     err_code <= ErrDefined;
                  end else if (overflow) begin
                     err      <= 1'b1;
                     err_code <= ErrOverflow;
                  end else begin
                     we        <= 1'b1;
                     lbidw     <= req_lbid;
                     typw      <= req_typ;
                     basew     <= next_base_q[15:0];
                     countw    <= req_count;
                     resp_base <= next_base_q[15:0];
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            StWrite: begin
               // we is only set for a successful request, so it doubles as the commit flag.
               if (we) begin
                  next_base_q      <= next_base_q + {1'b0, countw};
                  defined_q[lbidw] <= 1'b1;
               end
               we        <= 1'b0;
               done      <= 1'b0;
               err       <= 1'b0;
               err_code  <= ErrNone;
               req_ready <= 1'b1;
               state_q   <= StIdle;
            end
            default: begin
               state_q <= StInit;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_label_alloc_writer.sv
// Directed bench for label_alloc_writer (256-entry table, 64-word data memory).
module tb_label_alloc_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_lbid;
   logic [5:0]  req_typ;
   logic [15:0] req_count;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] resp_base;
   logic        busy;
   logic [7:0]  lbidw;
   logic [5:0]  typw;
   logic [15:0] basew;
   logic [15:0] countw;
   logic        we;

   int n_chk  = 0;
   int n_pass = 0;

   label_alloc_writer #(
      .LBIDWidth (8),
      .MemDepth  (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lbid  (req_lbid),
      .req_typ   (req_typ),
      .req_count (req_count),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .resp_base (resp_base),
      .busy      (busy),
      .lbidw     (lbidw),
      .typw      (typw),
      .basew     (basew),
      .countw    (countw),
      .we        (we)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic sweep_check(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         if (!(we === 1'b1 && lbidw === 8'(i) && typw === 6'd0 && basew === 16'd0 &&
               countw === 16'd0 && busy === 1'b1 && req_ready === 1'b0)) bad++;
      end
      chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_we_after"}, 32'(we), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (req_ready === 1'b1) break;
         @(posedge clk); #1;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic do_req(input string tag, input logic [7:0] id, input logic [5:0] typ,
                         input logic [15:0] cnt, input logic exp_err, input logic [1:0] exp_code,
                         input logic [15:0] exp_base);
      wait_ready(tag);
      req_lbid  = id;
      req_typ   = typ;
      req_count = cnt;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
      chk({tag, "_we"}, 32'(we), 32'(!exp_err));
      chk({tag, "_resp_base"}, 32'(resp_base), 32'(exp_base));
      if (!exp_err) begin
         chk({tag, "_lbidw"}, 32'(lbidw), 32'(id));
         chk({tag, "_typw"}, 32'(typw), 32'(typ));
         chk({tag, "_basew"}, 32'(basew), 32'(exp_base));
         chk({tag, "_countw"}, 32'(countw), 32'(cnt));
      end
      @(posedge clk); #1;
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      chk({tag, "_we_low"}, 32'(we), 32'd0);
      chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      clr       = 1'b0;
      req_valid = 1'b0;
      req_lbid  = '0;
      req_typ   = '0;
      req_count = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_resp_base", 32'(resp_base), 32'd0);
      reset = 1'b0;
      sweep_check("init_sweep");

      // Two definitions, then a redefinition error
      do_req("def3", 8'd3, 6'd5, 16'd10, 1'b0, 2'd0, 16'd0);
      do_req("def7", 8'd7, 6'd9, 16'd20, 1'b0, 2'd0, 16'd10);
      do_req("redef3", 8'd3, 6'd1, 16'd1, 1'b1, 2'd2, 16'd10);
      do_req("def9", 8'd9, 6'd4, 16'd4, 1'b0, 2'd0, 16'd30);

      // clr during WRITE: the write completes, then a fresh sweep
      wait_ready("clrw");
      req_lbid  = 8'd11;
      req_typ   = 6'd6;
      req_count = 16'd5;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      clr       = 1'b1;
      chk("clrw_done", 32'(done), 32'd1);
      chk("clrw_we", 32'(we), 32'd1);
      chk("clrw_lbidw", 32'(lbidw), 32'd11);
      chk("clrw_basew", 32'(basew), 32'd34);
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clrw_done_low", 32'(done), 32'd0);
      chk("clrw_we_low", 32'(we), 32'd0);
      chk("clrw_busy", 32'(busy), 32'd1);
      sweep_check("clr_sweep");
      do_req("redef3_after_clr", 8'd3, 6'd2, 16'd7, 1'b0, 2'd0, 16'd0);

      // clr beats a simultaneous request
      clr       = 1'b1;
      req_valid = 1'b1;
      req_lbid  = 8'd40;
      req_count = 16'd1;
      @(posedge clk); #1;
      clr       = 1'b0;
      req_valid = 1'b0;
      chk("clrreq_done", 32'(done), 32'd0);
      chk("clrreq_we", 32'(we), 32'd0);
      chk("clrreq_ready", 32'(req_ready), 32'd0);
      chk("clrreq_busy", 32'(busy), 32'd1);
      sweep_check("clr2_sweep");

      // Memory boundary (64 words)
      do_req("alloc60", 8'd1, 6'd3, 16'd60, 1'b0, 2'd0, 16'd0);
      do_req("alloc0_ok", 8'd5, 6'd3, 16'd0, 1'b0, 2'd0, 16'd60);
      do_req("alloc5_ovf", 8'd2, 6'd3, 16'd5, 1'b1, 2'd1, 16'd60);
      do_req("redef1_prio", 8'd1, 6'd3, 16'd5, 1'b1, 2'd2, 16'd60);
      do_req("alloc4_fit", 8'd2, 6'd7, 16'd4, 1'b0, 2'd0, 16'd60);
      do_req("alloc0_full", 8'd4, 6'd3, 16'd0, 1'b1, 2'd1, 16'd60);

      // Reset asserted mid-sweep at idx 100
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 101; i++) begin
         @(posedge clk); #1;
      end
      chk("mid_lbidw", 32'(lbidw), 32'd100);
      chk("mid_we", 32'(we), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_we", 32'(we), 32'd0);
      chk("async_lbidw", 32'(lbidw), 32'd0);
      chk("async_busy", 32'(busy), 32'd1);
      chk("async_resp_base", 32'(resp_base), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      sweep_check("restart_sweep");
      do_req("def_after_rst", 8'd1, 6'd1, 16'd2, 1'b0, 2'd0, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
